// File: rtl/rect_raster.sv
// rect_raster: fills an axis-aligned rectangle (or the whole screen) one pixel per clock,
// suppressing pixels that fall outside the visible area without wrapping them back on.
`default_nettype none
`timescale 1ns/100ps

module rect_raster #(
  parameter logic [7:0] SCREEN_W = 8'd160,
  parameter logic [6:0] SCREEN_H = 7'd120
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iStart,
  input  logic       iClear,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [7:0] iW,
  input  logic [7:0] iH,
  input  logic [5:0] iColour,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [5:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] x_base;
  logic [6:0] y_base;
  logic [7:0] w;
  logic [7:0] h;
  logic [5:0] col;
  logic [7:0] dx;
  logic [7:0] dy;

  logic       last_dx;
  logic       last_pix;
  logic [7:0] step_dx;
  logic [7:0] step_dy;
  logic [7:0] acc_x;
  logic [6:0] acc_y;
  logic [7:0] acc_w;
  logic [7:0] acc_h;
  logic [5:0] acc_col;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_vis;

  // The registered outputs always describe the pixel being presented, so the
  // combinational side computes the *next* pixel: the first one when accepting
  // in IDLE, otherwise the raster successor of (dx,dy).
  always_comb begin
    last_dx  = (dx == w - 8'd1);
    last_pix = last_dx && (dy == h - 8'd1);
    step_dx  = last_dx ? 8'd0 : dx + 8'd1;
    step_dy  = last_dx ? dy + 8'd1 : dy;

    if (iClear) begin
      acc_x   = 8'd0;
      acc_y   = 7'd0;
      acc_w   = SCREEN_W;
      acc_h   = {1'b0, SCREEN_H};
      acc_col = iColour;
    end else begin
      acc_x   = iX;
      acc_y   = iY;
      acc_w   = iW;
      acc_h   = iH;
      acc_col = iColour;
    end

    if (state == IDLE) begin
      pix_x = {1'b0, acc_x};
      pix_y = {2'b00, acc_y};
    end else begin
      pix_x = {1'b0, x_base} + {1'b0, step_dx};
      pix_y = {2'b00, y_base} + {1'b0, step_dy};
    end
    pix_vis = (pix_x < {1'b0, SCREEN_W}) && (pix_y < {2'b00, SCREEN_H});
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state   <= IDLE;
      x_base  <= 8'd0;
      y_base  <= 7'd0;
      w       <= 8'd0;
      h       <= 8'd0;
      col     <= 6'd0;
      dx      <= 8'd0;
      dy      <= 8'd0;
      oX      <= 8'd0;
      oY      <= 7'd0;
      oColour <= 6'd0;
      oPlot   <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oPlot <= 1'b0;
          oDone <= 1'b0;
          if (iClear || iStart) begin
            x_base <= acc_x;
            y_base <= acc_y;
            w      <= acc_w;
            h      <= acc_h;
            col    <= acc_col;
            dx     <= 8'd0;
            dy     <= 8'd0;
            oBusy  <= 1'b1;
            if (acc_w == 8'd0 || acc_h == 8'd0) begin
              state <= DONE;
              oDone <= 1'b1;
            end else begin
              state   <= DRAW;
              oX      <= pix_x[7:0];
              oY      <= pix_y[6:0];
              oColour <= acc_col;
              oPlot   <= pix_vis;
            end
          end
        end
        DRAW: begin
          if (last_pix) begin
            state <= DONE;
            oPlot <= 1'b0;
            oDone <= 1'b1;
          end else begin
            dx    <= step_dx;
            dy    <= step_dy;
            oX    <= pix_x[7:0];
            oY    <= pix_y[6:0];
            oPlot <= pix_vis;
          end
        end
        DONE: begin
          state <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oPlot <= 1'b0;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
